// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the memory-unit state encoding.
// Imported by the memory unit and its storage array.
package cpu_pkg;

    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int A_W    = WORD_W - OP_W;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        PROG
    } mem_state_t;

endpackage

// File: rtl/ram_array.sv
// Word-wide storage with one synchronous write port and an asynchronous read port.
module ram_array
    import cpu_pkg::*;
#(
    parameter int WORD_W = cpu_pkg::WORD_W,
    parameter int A_W    = cpu_pkg::A_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [A_W-1:0]    waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [A_W-1:0]    raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**A_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_unit.sv
// Memory unit: MAR/MDR registers, a power-up clearing sweep, and a host
// programming port, all sharing the single write port of ram_array.
module mem_unit
    import cpu_pkg::*;
#(
    parameter int WORD_W = cpu_pkg::WORD_W,
    parameter int OP_W   = cpu_pkg::OP_W,
    parameter int A_W    = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] sysbus_in,
    input  logic              load_MAR,
    input  logic              load_MDR,
    input  logic              CS,
    input  logic              R_NW,
    input  logic              prog_en,
    input  logic              host_valid,
    input  logic [A_W-1:0]    host_addr,
    input  logic [WORD_W-1:0] host_data,
    output logic              host_ready,
    output logic              hold,
    output logic [WORD_W-1:0] mdr_q,
    output logic [A_W-1:0]    mar_q,
    output logic              err
);

    mem_state_t        state_q, state_d;
    logic [A_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [A_W-1:0]    mar_d;
    logic [WORD_W-1:0] mdr_d;
    logic              err_q, err_d;

    logic              cpu_read, cpu_write;
    logic              ram_we;
    logic [A_W-1:0]    ram_waddr;
    logic [WORD_W-1:0] ram_wdata, ram_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            err_q     <= err_d;
        end
    end

    // prog_en is only looked at once the clearing sweep has finished.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_ptr_q == {A_W{1'b1}}) state_d = RUN;
            RUN:     if (prog_en) state_d = PROG;
            PROG:    if (!prog_en) state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Each state owns the write port exclusively; reset blocks any write at its edge.
    always_comb begin
        hold       = 1'b0;
        host_ready = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = mar_q;
        ram_wdata  = mdr_q;
        case (state_q)
            CLEAR: begin
                hold      = 1'b1;
                ram_we    = !reset;
                ram_waddr = clr_ptr_q;
                ram_wdata = '0;
            end
            PROG: begin
                hold       = 1'b1;
                host_ready = 1'b1;
                ram_we     = host_valid && !reset;
                ram_waddr  = host_addr;
                ram_wdata  = host_data;
            end
            RUN: begin
                ram_we = cpu_write && !reset;
            end
            default: begin
                hold = 1'b1;
            end
        endcase
    end

    // A CS access is dropped when load_MDR competes for the MDR or the sequencer is held.
    always_comb begin
        cpu_read  = (state_q == RUN) && CS && R_NW && !load_MDR;
        cpu_write = (state_q == RUN) && CS && !R_NW && !load_MDR;
        clr_ptr_d = (state_q == CLEAR) ? clr_ptr_q + 1'b1 : '0;
        mar_d     = load_MAR ? sysbus_in[A_W-1:0] : mar_q;
        if (load_MDR) begin
            mdr_d = sysbus_in;
        end else if (cpu_read) begin
            mdr_d = ram_rdata;
        end else begin
            mdr_d = mdr_q;
        end
        err_d = err_q | (CS & (hold | load_MDR));
    end

    assign err = err_q;

    ram_array #(
        .WORD_W(WORD_W),
        .A_W   (A_W)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(mar_q),
        .rdata(ram_rdata)
    );

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter WORD_W, default 8, data word width; matches the sequencer's WORD_W.
REQ-002 Parameter OP_W, default 3, opcode width.
REQ-003 Parameter A_W, default WORD_W-OP_W (5), address width; depth = 2**A_W words (32).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sysbus_in  input  WORD_W  current system bus value, source for MAR/MDR loads.
REQ-007 load_MAR, load_MDR, CS, R_NW  input  1 each  sequencer controls (CS=1 with R_NW=1 is read; CS=1 with R_NW=0 is write).
REQ-008 prog_en  input  1  level request to enter host programming mode.
REQ-009 host_valid  input  1  host write request, qualified by host_ready.
REQ-010 host_addr  input  A_W  host write address.
REQ-011 host_data  input  WORD_W  host write data.
REQ-012 host_ready  output  1  high only in state PROG.
REQ-013 hold  output  1  high in CLEAR and PROG; the sequencer must not advance while high.
REQ-014 mdr_q  output  WORD_W  MDR contents; top level drives this onto the bus when MDR_bus is high.
REQ-015 mar_q  output  A_W  MAR contents.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 State machine states: CLEAR, RUN, PROG; the encoding is a package enum.
REQ-018 CLEAR:
- Writes 0 to mem[clr_ptr] every cycle; clr_ptr increments from 0.
- On clr_ptr = 2**A_W-1, that word is written and the next state is RUN.
- CLEAR lasts exactly 2**A_W cycles.
REQ-019 RUN -> PROG when prog_en=1; PROG -> RUN when prog_en=0, effective the next cycle; prog_en is ignored in CLEAR.
REQ-020 PROG: each cycle with host_valid=1 writes host_data to mem[host_addr] at that edge; one word per cycle; host_ready stays 1 throughout PROG.
REQ-021 host_valid is ignored outside PROG; no write occurs.
REQ-022 load_MAR=1: MAR <= sysbus_in[A_W-1:0] at the edge; the upper bits are discarded.
REQ-023 MDR update priority in RUN:
- load_MDR=1: MDR <= sysbus_in.
- Else CS=1 and R_NW=1: MDR <= mem[MAR], with MAR sampled before the edge.
- Read data is visible on mdr_q one cycle after the CS cycle.
REQ-024 Write: CS=1 and R_NW=0 in RUN writes the pre-edge MDR into mem[MAR].
REQ-025 load_MDR and CS=1 in the same cycle: the load_MDR action is performed, the CS access is dropped, and err is set to 1.
REQ-026 CS=1 while hold=1: the access is ignored, MAR/MDR are unchanged, and err is set to 1.
REQ-027 load_MAR and load_MDR are honoured in every state.
REQ-028 Simultaneous load_MAR and CS: the access uses the old MAR and the new MAR takes effect next cycle.
REQ-029 Address wrap: clr_ptr wraps naturally; host_addr and MAR are always in range because memory depth equals 2**A_W.
REQ-030 err clears only on reset.

Reset
REQ-031 reset=1 at an edge sets:
- state <= CLEAR, clr_ptr <= 0;
- MAR <= 0, MDR <= 0, err <= 0.
After reset, outputs are hold=1, host_ready=0, mdr_q=0, mar_q=0, err=0.
REQ-032 Reset asserted mid-CLEAR or mid-PROG restarts CLEAR at address 0; partial host writes are then overwritten with 0.
REQ-033 Memory array contents are not reset directly; they are zeroed only by CLEAR.

Structure
REQ-034 The shared package cpu_pkg holds WORD_W, OP_W, A_W defaults and the enum mem_state_t {CLEAR, RUN, PROG}.
REQ-035 The storage array is sub-module ram_array:
- single write port, synchronous write;
- asynchronous read at MAR;
- mem_unit muxes the write address/data among clear, host and CPU sources.
REQ-036 Write-source priority: CLEAR > PROG host > RUN CPU. The states are exclusive, so at most one write occurs per cycle.

Verification
REQ-037 Reset, then count cycles -> hold=1 for exactly 32 cycles, then 0; a read of every address returns 8'h00.
REQ-038 prog_en=1, then host writes 8'hA5@3 and 8'h3C@31 on consecutive cycles, then prog_en=0 -> after sysbus_in=8'h03 with load_MAR, a CS/R_NW read gives mdr_q=8'hA5 one cycle later; address 31 gives 8'h3C.
REQ-039 Write path:
- Stimulus: load_MAR with sysbus_in=8'h07; load_MDR with 8'h5A; CS=1, R_NW=0; then CS=1, R_NW=1 after load_MDR with 8'h00.
- Response: mdr_q=8'h5A.
REQ-040 load_MDR with 8'h11 and CS=1, R_NW=1 in the same cycle -> mdr_q=8'h11 and err=1, remaining 1 until reset.
REQ-041 CS=1 during CLEAR -> err=1 and MAR/MDR unchanged; reset at CLEAR cycle 10 -> hold stays 1 for 32 further cycles.
